fft_tw4_seq: RTL and testbench
==============================

# fft_tw4_seq

Twiddle sequencer and stage controller for one radix-2² FFT stage. It counts incoming samples within a frame and drives the 2-bit address of the 4-entry twiddle ROM. It also drives the butterfly half-select of the stage datapath, and tracks the datapath pipeline so it can flag output valid and frame completion. It sits between the sample source and the stage butterfly/multiplier datapath, and is the only writer of the twiddle ROM address.

## Interface
- LOG2N, 6: log2 of frame length N (N = 64 default); must be ≥ 2
- STAGE_LAT, 3: datapath latency in cycles from twiddle valid to stage output valid; must be ≥ 1
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- clr  in  1  synchronous abort; returns block to IDLE
- din_valid  in  1  sample present at stage input
- din_ready  out  1  block accepts a sample this cycle
- tw_addr  out  2  twiddle ROM address, registered
- tw_valid  out  1  tw_addr/bfly_sel belong to an accepted sample
- bfly_sel  out  1  0 = first half of butterfly span (store), 1 = second half (compute)
- frame_start  out  1  one-cycle pulse with tw_valid of sample k = 0
- dout_valid  out  1  stage output valid (tw_valid delayed STAGE_LAT)
- frame_done  out  1  one-cycle pulse with dout_valid of sample k = N−1
- busy  out  1  state ≠ IDLE
- frame_cnt  out  8  completed frames, wraps 255 → 0

## Operation
- Accept: accept = din_valid & din_ready. Sample index k (LOG2N bits) increments only on accept. k returns to 0 after N−1.
- States:
  - IDLE: din_ready = 1. Accept → RUN.
  - RUN: din_ready = 1. Accept with k = N−1 → DRAIN.
  - DRAIN: din_ready = 0. frame_done → IDLE.
- Registered on accept:
  - tw_addr ← k[LOG2N−1:LOG2N−2], i.e. quarter index 0..3. Address 3 selects the −j twiddle.
  - bfly_sel ← k[LOG2N−1].
  - tw_valid ← 1.
  - frame_start ← (k == 0).
- Without an accept: tw_valid and frame_start are 0, and tw_addr and bfly_sel hold their values.
- Pipe: STAGE_LAT-deep shift register carries {tw_valid, last}, where last = (k == N−1) at accept.
  - dout_valid = valid at pipe tail.
  - frame_done = dout_valid & last at pipe tail.
- frame_cnt increments on frame_done.
- clr: next edge forces k = 0, state IDLE, pipe cleared, tw_valid/frame_start/dout_valid/frame_done = 0. tw_addr and bfly_sel go to 0; frame_cnt holds. clr has priority over a simultaneous accept, which is dropped.
- Reset values (rstn low, async): state IDLE, k = 0, din_ready = 1, tw_addr = 0, tw_valid = 0, bfly_sel = 0, frame_start = 0, dout_valid = 0, frame_done = 0, busy = 0, frame_cnt = 0, pipe cleared.
- din_valid while in DRAIN is ignored, not queued. The source must hold the sample until din_ready.

## Timing
- Accept at edge c → tw_valid/tw_addr/bfly_sel visible in cycle c+1 → dout_valid in cycle c+1+STAGE_LAT.
- Last accept at edge c:
  - DRAIN from cycle c+1.
  - frame_done in cycle c+1+STAGE_LAT.
  - IDLE and din_ready = 1 from cycle c+2+STAGE_LAT.
  - din_ready is therefore low for exactly STAGE_LAT+1 cycles.
- Back-to-back full-rate frames have a throughput of N samples per N+STAGE_LAT+1 cycles.
- Gaps in din_valid stall k and insert bubbles in tw_valid/dout_valid. There are no ordering side effects.
- The ROM is combinational, so twiddle data is valid in the same cycle as tw_valid.

## Test plan
- Reset (LOG2N = 6, STAGE_LAT = 3): assert rstn low mid-frame at k = 37 → all outputs at reset values immediately. After release, the first accept gives tw_addr = 0 and frame_start = 1.
- Continuous 64 accepts from cycle 0:
  - tw_addr = 0 for k 0–15, 1 for 16–31, 2 for 32–47, 3 for 48–63.
  - bfly_sel = 0 for k 0–31, 1 for k 32–63.
  - frame_start in cycle 1; frame_done in cycle 67; din_ready low in cycles 64–67; frame_cnt = 1.
- din_valid toggling 1,0,1,0 → same tw_addr sequence per accepted sample. dout_valid mirrors tw_valid 3 cycles later. 64 accepts complete the frame.
- din_valid held high through DRAIN → no accept while din_ready = 0. The next frame's k = 0 accept occurs in cycle 68, with frame_start in cycle 69.
- clr asserted at k = 20, coincident with din_valid → that sample is dropped and state is IDLE. No frame_done occurs and frame_cnt is unchanged. The next accept gives tw_addr = 0 and frame_start = 1.
- 256 consecutive frames → frame_cnt wraps to 0 on the 256th frame_done.

Source files
------------

// File: rtl/fft_tw4_seq.sv
// fft_tw4_seq: twiddle ROM address sequencer and stage controller for one radix-2^2 FFT stage.
// Counts accepted samples per frame, drives tw_addr/bfly_sel, and tracks the datapath pipe.
//
// state | meaning
// IDLE  | waiting for sample k = 0 of a new frame
// RUN   | frame in progress, accepting samples
// DRAIN | last sample accepted; input stalled until it leaves the datapath
module fft_tw4_seq #(
  parameter int LOG2N     = 6,
  parameter int STAGE_LAT = 3
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [1:0] tw_addr,
  output logic       tw_valid,
  output logic       bfly_sel,
  output logic       frame_start,
  output logic       dout_valid,
  output logic       frame_done,
  output logic       busy,
  output logic [7:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [LOG2N-1:0] K_LAST = '1;

  state_t               state_q;
  logic [LOG2N-1:0]     k_q;
  logic [LOG2N-1:0]     k_d;
  logic [1:0]           tw_addr_q;
  logic                 tw_valid_q;
  logic                 bfly_sel_q;
  logic                 frame_start_q;
  logic                 last_q;
  logic [STAGE_LAT-1:0] pv_q;
  logic [STAGE_LAT-1:0] pl_q;
  logic [7:0]           frame_cnt_q;
  logic [7:0]           frame_cnt_d;
  logic                 accept;
  logic                 k_is_last;
  logic                 done;

  assign din_ready   = (state_q != DRAIN);
  assign accept      = din_valid & din_ready;
  assign k_is_last   = (k_q == K_LAST);
  assign done        = pv_q[STAGE_LAT-1] & pl_q[STAGE_LAT-1];
  // k is exactly LOG2N bits wide, so N-1 wraps to 0 without a compare
  assign k_d         = k_q + LOG2N'(1);
  assign frame_cnt_d = frame_cnt_q + 8'd1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      k_q           <= '0;
      tw_addr_q     <= '0;
      tw_valid_q    <= 1'b0;
      bfly_sel_q    <= 1'b0;
      frame_start_q <= 1'b0;
      last_q        <= 1'b0;
      pv_q          <= '0;
      pl_q          <= '0;
      frame_cnt_q   <= '0;
    end else if (clr) begin
      state_q       <= IDLE;
      k_q           <= '0;
      tw_addr_q     <= '0;
      tw_valid_q    <= 1'b0;
      bfly_sel_q    <= 1'b0;
      frame_start_q <= 1'b0;
      last_q        <= 1'b0;
      pv_q          <= '0;
      pl_q          <= '0;
    end else begin
      tw_valid_q    <= accept;
      frame_start_q <= accept & (k_q == '0);
      last_q        <= accept & k_is_last;
      if (accept) begin
        k_q        <= k_d;
        tw_addr_q  <= k_q[LOG2N-1 -: 2];
        bfly_sel_q <= k_q[LOG2N-1];
      end
      // pipe mirrors the datapath latency from twiddle valid to stage output
      pv_q[0] <= tw_valid_q;
      pl_q[0] <= last_q;
      for (int i = 1; i < STAGE_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
      end
      if (done) begin
        frame_cnt_q <= frame_cnt_d;
      end
      case (state_q)
        IDLE:    if (accept) state_q <= RUN;
        RUN:     if (accept && k_is_last) state_q <= DRAIN;
        DRAIN:   if (done) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tw_addr     = tw_addr_q;
  assign tw_valid    = tw_valid_q;
  assign bfly_sel    = bfly_sel_q;
  assign frame_start = frame_start_q;
  assign dout_valid  = pv_q[STAGE_LAT-1];
  assign frame_done  = done;
  assign busy        = (state_q != IDLE);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fft_tw4_seq.sv
// Bench for fft_tw4_seq: event-scheduled reference model (outputs predicted per cycle
// from accept times), directed frames, clr/reset cases and randomized traffic.
module tb_fft_tw4_seq;
  localparam int LOG2N = 6;
  localparam int L     = 3;
  localparam int N     = 64;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       clr = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [1:0] tw_addr;
  logic       tw_valid;
  logic       bfly_sel;
  logic       frame_start;
  logic       dout_valid;
  logic       frame_done;
  logic       busy;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  fft_tw4_seq #(.LOG2N(LOG2N), .STAGE_LAT(L)) dut (
    .clk(clk), .rstn(rstn), .clr(clr), .din_valid(din_valid),
    .din_ready(din_ready), .tw_addr(tw_addr), .tw_valid(tw_valid),
    .bfly_sel(bfly_sel), .frame_start(frame_start), .dout_valid(dout_valid),
    .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // reference model: sample count, time input reopens, and a per-cycle schedule of outputs
  int cyc = 0;
  int mk = 0;
  int ready_from = 0;
  bit m_tv, m_fs, m_bf;
  int m_addr, m_fc;
  bit sv [0:65535];
  bit sl [0:65535];
  int fs_cycles[$];
  int fd_cycles[$];
  int fd_count = 0;
  int c0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    mk = 0; ready_from = cyc;
    m_tv = 0; m_fs = 0; m_bf = 0; m_addr = 0; m_fc = 0;
    for (int i = cyc; i <= cyc + L + 2; i++) begin
      sv[i] = 0; sl[i] = 0;
    end
  endtask

  task automatic reset_chk();
    chk("rst_din_ready", din_ready, 1);
    chk("rst_tw_addr", tw_addr, 0);
    chk("rst_tw_valid", tw_valid, 0);
    chk("rst_bfly_sel", bfly_sel, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
  endtask

  // called at a negedge: check this cycle, drive inputs, advance model over the next edge
  task automatic step(input bit dv, input bit c);
    bit exp_ready, acc;
    exp_ready = (cyc >= ready_from);
    chk("din_ready", din_ready, exp_ready);
    chk("tw_valid", tw_valid, m_tv);
    chk("tw_addr", tw_addr, m_addr);
    chk("bfly_sel", bfly_sel, m_bf);
    chk("frame_start", frame_start, m_fs);
    chk("dout_valid", dout_valid, sv[cyc]);
    chk("frame_done", frame_done, sv[cyc] & sl[cyc]);
    chk("busy", busy, (mk != 0) || !exp_ready);
    chk("frame_cnt", frame_cnt, m_fc);
    if (frame_start === 1'b1) fs_cycles.push_back(cyc);
    if (frame_done === 1'b1) begin fd_cycles.push_back(cyc); fd_count++; end
    din_valid = dv;
    clr = c;
    acc = dv && exp_ready && !c;
    if (c) begin
      mk = 0; ready_from = cyc + 1;
      m_tv = 0; m_fs = 0; m_addr = 0; m_bf = 0;
      for (int i = cyc + 1; i <= cyc + 1 + L; i++) begin
        sv[i] = 0; sl[i] = 0;
      end
    end else begin
      if (sv[cyc] && sl[cyc]) m_fc = (m_fc + 1) % 256;
      m_tv = acc;
      m_fs = acc && (mk == 0);
      if (acc) begin
        m_addr = mk / (N / 4);
        m_bf = (mk >= N / 2);
        sv[cyc + 1 + L] = 1;
        sl[cyc + 1 + L] = (mk == N - 1);
        if (mk == N - 1) begin
          mk = 0; ready_from = cyc + 2 + L;
        end else begin
          mk++;
        end
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    #2 rstn = 1'b0;
    #1;
    reset_chk();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();

    // one full-rate frame from cycle 0
    c0 = cyc; fs_cycles.delete(); fd_cycles.delete();
    repeat (N) step(1, 0);
    repeat (8) step(0, 0);
    chk("fA_fs_count", fs_cycles.size(), 1);
    chk("fA_fs_cycle", (fs_cycles.size() > 0) ? fs_cycles[0] - c0 : -1, 1);
    chk("fA_fd_cycle", (fd_cycles.size() > 0) ? fd_cycles[0] - c0 : -1, 67);
    chk("fA_frame_cnt", frame_cnt, 1);

    // alternating din_valid
    fd_count = 0;
    for (int i = 0; i < 2 * N; i++) step(i % 2 == 0, 0);
    repeat (8) step(0, 0);
    chk("fB_fd_count", fd_count, 1);
    chk("fB_frame_cnt", frame_cnt, 2);

    // din_valid held through DRAIN
    c0 = cyc; fs_cycles.delete();
    repeat (136) step(1, 0);
    repeat (4) step(0, 0);
    chk("fC_fs_count", fs_cycles.size(), 2);
    chk("fC_fs2_cycle", (fs_cycles.size() > 1) ? fs_cycles[1] - c0 : -1, 69);
    chk("fC_frame_cnt", frame_cnt, 4);

    // clr at k = 20 with a coincident sample
    fd_count = 0;
    repeat (20) step(1, 0);
    step(1, 1);
    chk("clr_busy", busy, 0);
    chk("clr_tw_valid", tw_valid, 0);
    repeat (8) step(0, 0);
    chk("clr_fd_count", fd_count, 0);
    chk("clr_frame_cnt", frame_cnt, 4);
    step(1, 0);
    chk("clr_next_fs", frame_start, 1);
    chk("clr_next_addr", tw_addr, 0);

    // randomized traffic with occasional clr
    repeat (2000) step($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);

    // async reset mid-frame at k = 37
    step(0, 1);
    repeat (37) step(1, 0);
    chk("pre_rst_addr", tw_addr, 2);
    din_valid = 1'b1;
    rstn = 1'b0;
    #1;
    reset_chk();
    @(negedge clk);
    rstn = 1'b1;
    cyc++;
    model_reset();
    step(1, 0);
    chk("post_rst_fs", frame_start, 1);
    chk("post_rst_addr", tw_addr, 0);
    chk("post_rst_tv", tw_valid, 1);

    // 256 back-to-back frames: frame_cnt wraps to 0
    step(0, 1);
    fd_count = 0;
    repeat (256 * (N + L + 1)) step(1, 0);
    repeat (4) step(0, 0);
    chk("wrap_fd_count", fd_count, 256);
    chk("wrap_frame_cnt", frame_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
